intt_sub_half: RTL and testbench

Inverse-direction companion to the forward-NTT modular adder: a streaming unit that takes coefficient pairs and produces both the modular sum and the modular difference, optionally halved mod q, for Gentleman-Sande INTT stages. Covers Kyber (dual 12-bit lanes, q = 3329) and Dilithium (single 24-bit lane, q = 8380417). It sits between the coefficient RAM read port and the twiddle multiplier. It has a valid/ready handshake, a 2-stage pipeline and a per-polynomial beat counter.

---
 rtl/intt_sub_half_pkg.sv | 52 +++++
 rtl/intt_sub_half_mod_half.sv | 16 +
 rtl/intt_sub_half.sv | 116 +++++++++++
 tb/tb_intt_sub_half.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intt_sub_half_pkg.sv
// Shared constants, lane-mode encoding and the corrected modular add/sub
// helpers for the Kyber and Dilithium lanes of intt_sub_half.
package intt_sub_half_pkg;

  localparam int KQ_W = 12;
  localparam int DQ_W = 24;
  localparam int KQ   = 3329;
  localparam int DQ   = 8380417;

  localparam logic [KQ_W:0] KQ_X = (KQ_W + 1)'(KQ);
  localparam logic [DQ_W:0] DQ_X = (DQ_W + 1)'(DQ);

  typedef enum logic {
    MODE_KYBER = 1'b0,
    MODE_DIL   = 1'b1
  } mode_e;

  // Each helper applies exactly one conditional correction; canonical inputs
  // guarantee that is enough.
  function automatic logic [KQ_W-1:0] add_mod_k(input logic [KQ_W-1:0] a,
                                                input logic [KQ_W-1:0] b);
    logic [KQ_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= KQ_X) s = s - KQ_X;
    return s[KQ_W-1:0];
  endfunction

  function automatic logic [KQ_W-1:0] sub_mod_k(input logic [KQ_W-1:0] a,
                                                input logic [KQ_W-1:0] b);
    logic [KQ_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[KQ_W]) d = d + KQ_X;
    return d[KQ_W-1:0];
  endfunction

  function automatic logic [DQ_W-1:0] add_mod_d(input logic [DQ_W-1:0] a,
                                                input logic [DQ_W-1:0] b);
    logic [DQ_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DQ_X) s = s - DQ_X;
    return s[DQ_W-1:0];
  endfunction

  function automatic logic [DQ_W-1:0] sub_mod_d(input logic [DQ_W-1:0] a,
                                                input logic [DQ_W-1:0] b);
    logic [DQ_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DQ_W]) d = d + DQ_X;
    return d[DQ_W-1:0];
  endfunction

endpackage

// File: rtl/intt_sub_half_mod_half.sv
// Combinational x/2 mod q for an odd modulus q: odd x is lifted by q first,
// using an intermediate one bit wider than the lane so the carry survives.
module mod_half #(
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  logic [W:0] wide;

  assign wide = {1'b0, x_i} + (x_i[0] ? (W + 1)'(Q) : '0);
  assign y_o  = wide[W:1];

endmodule

// File: rtl/intt_sub_half.sv
// Streaming Gentleman-Sande butterfly front end: modular sum and difference
// over a 2-stage valid/ready pipeline. Define INTT_HALF_EN to halve both
// results mod q in stage 2.
module intt_sub_half
  import intt_sub_half_pkg::*;
#(
  parameter int POLY_N = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [23:0]               in_a,
  input  logic [23:0]               in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [23:0]               out_sum,
  output logic [23:0]               out_diff,
  output logic                      out_last,
  output logic [$clog2(POLY_N)-1:0] coef_cnt
);

  localparam int                CNT_W   = $clog2(POLY_N);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(POLY_N - 1);

  logic              en;
  logic [23:0]       sum_c, diff_c;
  logic              s1_valid_q;
  logic [23:0]       s1_sum_q, s1_diff_q;
  logic [1:0][23:0]  s2_val;
  logic              out_valid_q;
  logic [23:0]       out_sum_q, out_diff_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Both stages move together; a held output back-pressures the input.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum_c  = {add_mod_k(in_a[23:12], in_b[23:12]), add_mod_k(in_a[11:0], in_b[11:0])};
    diff_c = {sub_mod_k(in_a[23:12], in_b[23:12]), sub_mod_k(in_a[11:0], in_b[11:0])};
    if (mode_e'(mode) == MODE_DIL) begin
      sum_c  = add_mod_d(in_a, in_b);
      diff_c = sub_mod_d(in_a, in_b);
    end
  end

`ifdef INTT_HALF_EN
  mode_e s1_mode_q;

  always_ff @(posedge clk) begin
    if (!rst)                  s1_mode_q <= MODE_KYBER;
    else if (en && in_valid)   s1_mode_q <= mode_e'(mode);
  end

  for (genvar g = 0; g < 2; g++) begin : g_half
    logic [23:0]     x;
    logic [KQ_W-1:0] k_hi, k_lo;
    logic [DQ_W-1:0] d_full;

    assign x = (g == 0) ? s1_sum_q : s1_diff_q;

    mod_half #(.W(KQ_W), .Q(KQ)) u_k_hi (.x_i(x[23:12]), .y_o(k_hi));
    mod_half #(.W(KQ_W), .Q(KQ)) u_k_lo (.x_i(x[11:0]),  .y_o(k_lo));
    mod_half #(.W(DQ_W), .Q(DQ)) u_d    (.x_i(x),        .y_o(d_full));

    assign s2_val[g] = (s1_mode_q == MODE_DIL) ? d_full : {k_hi, k_lo};
  end
`else
  assign s2_val[0] = s1_sum_q;
  assign s2_val[1] = s1_diff_q;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_diff_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_diff_q  <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        s1_valid_q  <= in_valid;
        out_valid_q <= s1_valid_q;
        if (in_valid) begin
          s1_sum_q  <= sum_c;
          s1_diff_q <= diff_c;
        end
        if (s1_valid_q) begin
          out_sum_q  <= s2_val[0];
          out_diff_q <= s2_val[1];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_diff  = out_diff_q;
  assign coef_cnt  = cnt_q;
  assign out_last  = out_valid_q && (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_intt_sub_half.sv
// Self-checking bench for intt_sub_half: directed literal vectors, a stalled
// mixed-mode stream, a random-backpressure polynomial run and a mid-flight reset.
module tb_intt_sub_half;

  localparam int POLY_N = 256;
  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_a = '0, in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_sum, out_diff;
  logic        out_last;
  logic [7:0]  coef_cnt;

  intt_sub_half #(.POLY_N(POLY_N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_diff(out_diff), .out_last(out_last), .coef_cnt(coef_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the modular definitions; halving is
  // multiplication by the inverse of 2, i.e. (q+1)/2.
  function automatic int unsigned half_mod(input int unsigned x, input int unsigned q);
    longint unsigned p;
    p = longint'(x) * longint'((q + 1) / 2);
    return int'(p % longint'(q));
  endfunction

  function automatic int unsigned lane_res(input int unsigned x, input int unsigned y,
                                           input int unsigned q, input bit diff);
    int unsigned r;
    r = diff ? (x + q - y) % q : (x + y) % q;
`ifdef INTT_HALF_EN
    r = half_mod(r, q);
`endif
    return r;
  endfunction

  function automatic logic [47:0] ref_beat(input logic m, input logic [23:0] a, input logic [23:0] b);
    logic [23:0] s, d;
    if (m) begin
      s = 24'(lane_res(a, b, DQ, 1'b0));
      d = 24'(lane_res(a, b, DQ, 1'b1));
    end else begin
      s = {12'(lane_res(a[23:12], b[23:12], KQ, 1'b0)), 12'(lane_res(a[11:0], b[11:0], KQ, 1'b0))};
      d = {12'(lane_res(a[23:12], b[23:12], KQ, 1'b1)), 12'(lane_res(a[11:0], b[11:0], KQ, 1'b1))};
    end
    return {s, d};
  endfunction

  // Model state: beats in flight in order, output beat index within a polynomial.
  logic [47:0] exp_q[$];
  int          m_cnt      = 0;
  int          beats_out  = 0;
  int          acc_in     = 0;
  int          last_idx[$];
  bit          rst_was_low = 1'b0;

  // Compare process: inputs change 2 time units after posedge, so at negedge
  // outputs reflect the last edge and the inputs seen are those the next edge takes.
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst_was_low) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_diff", out_diff, 0);
      check("rst_out_last", out_last, 0);
      check("rst_coef_cnt", coef_cnt, 0);
      check("rst_in_ready", in_ready, 1);
    end
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = exp_q[0];
        check("sum", out_sum, e[47:24]);
        check("diff", out_diff, e[23:0]);
        check("coef_cnt", coef_cnt, m_cnt);
        check("out_last", out_last, m_cnt == POLY_N - 1);
      end
    end else begin
      check("out_last_idle", out_last, 0);
    end
    if (!rst) begin
      exp_q.delete();
      last_idx.delete();
      m_cnt = 0; beats_out = 0; acc_in = 0;
      rst_was_low = 1'b1;
    end else begin
      rst_was_low = 1'b0;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        beats_out++;
        if (out_last) last_idx.push_back(beats_out);
        m_cnt = (m_cnt + 1) % POLY_N;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(mode, in_a, in_b));
        acc_in++;
      end
    end
  end

  task automatic drive(input bit v, input logic m, input logic [23:0] a,
                       input logic [23:0] b, input bit ordy);
    @(posedge clk); #2;
    in_valid = v; mode = m; in_a = a; in_b = b; out_ready = ordy;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  function automatic logic [23:0] rand_op(input logic m);
    if (m) return 24'($urandom_range(0, DQ - 1));
    return {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
  endfunction

  // One beat, then idle; checks exactly two edges after acceptance.
  task automatic single(input string tag, input logic m, input logic [23:0] a,
                        input logic [23:0] b, input logic [23:0] es, input logic [23:0] ed);
    drive(1'b1, m, a, b, 1'b1);
    drive(1'b0, m, '0, '0, 1'b1);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, out_sum, es);
    check({tag, "_diff"}, out_diff, ed);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [23:0] held_s, held_d;
    logic        m;
    int          n;

    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Directed literal vectors.
`ifdef INTT_HALF_EN
    single("kyb", 1'b0, {12'd3000, 12'd5}, {12'd1000, 12'd10}, {12'd2000, 12'd1672}, {12'd1000, 12'd1662});
    single("dil_top", 1'b1, 24'd8380416, 24'd1, 24'd0, 24'd8380416);
    single("dil_bor", 1'b1, 24'd0, 24'd1, 24'd4190209, 24'd4190208);
`else
    single("kyb", 1'b0, {12'd3000, 12'd5}, {12'd1000, 12'd10}, {12'd671, 12'd15}, {12'd2000, 12'd3324});
    single("dil_top", 1'b1, 24'd8380416, 24'd1, 24'd0, 24'd8380415);
    single("dil_bor", 1'b1, 24'd0, 24'd1, 24'd1, 24'd8380416);
`endif
    wait_drain("directed");

    // Alternating-mode stream with a 3-cycle stall in the middle.
    for (int i = 0; i < 16; i++) begin
      m = 1'(i % 2);
      if (i >= 6 && i <= 8) begin
        drive(1'b1, m, rand_op(m), rand_op(m), 1'b0);
        #1;
        check("stall_in_ready", in_ready, 0);
        if (i == 6) begin
          held_s = out_sum; held_d = out_diff;
        end else begin
          check("stall_hold_sum", out_sum, held_s);
          check("stall_hold_diff", out_diff, held_d);
        end
      end else begin
        drive(1'b1, m, rand_op(m), rand_op(m), 1'b1);
      end
    end
    wait_drain("stream");

    // Two polynomials with random valid and random backpressure.
    do_reset();
    n = 0;
    while (beats_out < 2 * POLY_N && n < 20000) begin
      m = 1'($urandom_range(0, 1));
      drive((acc_in < 2 * POLY_N) && ($urandom_range(0, 3) != 0), m, rand_op(m), rand_op(m),
            $urandom_range(0, 3) != 0);
      n++;
    end
    check("poly_beats", beats_out, 2 * POLY_N);
    check("poly_last_count", last_idx.size(), 2);
    if (last_idx.size() == 2) begin
      check("poly_last_1", last_idx[0], POLY_N);
      check("poly_last_2", last_idx[1], 2 * POLY_N);
    end
    wait_drain("poly");

    // Reset with two beats in flight at coef_cnt = 100.
    do_reset();
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, rand_op(1'b1), rand_op(1'b1), 1'b1);
    wait_drain("pre_rst");
    drive(1'b1, 1'b0, rand_op(1'b0), rand_op(1'b0), 1'b1);
    drive(1'b1, 1'b1, rand_op(1'b1), rand_op(1'b1), 1'b1);
    @(posedge clk); #2;
    check("pre_rst_cnt", coef_cnt, 100);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_cnt", coef_cnt, 0);
    check("post_rst_sum", out_sum, 0);
    check("post_rst_diff", out_diff, 0);
    check("post_rst_ready", in_ready, 1);
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 1'b1, 24'd0, 24'd1, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("after_rst_valid", out_valid, 1);
    check("after_rst_cnt", coef_cnt, 0);
    wait_drain("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
